// File: rtl/down_counter_timer.sv
// down_counter_timer
//   Loadable WIDTH-bit countdown timer. The host loads a start value, starts
//   the timer, and the count decrements once per enabled cycle down to zero,
//   pulsing tc at terminal count. With auto_reload set the count is restored
//   from the reload register at terminal count and the timer keeps running,
//   giving a periodic tick.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   load         in   1      capture load_val into count and reload register
//   load_val     in   WIDTH  value captured on load
//   start        in   1      begin counting (from IDLE or DONE)
//   stop         in   1      abort counting and hold count (RUN only)
//   en           in   1      count enable / prescale strobe
//   auto_reload  in   1      1: periodic reload, 0: one-shot
//   count        out  WIDTH  current counter value
//   busy         out  1      high while running
//   tc           out  1      one-cycle terminal-count pulse
//   done         out  1      high after a one-shot completes

module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // State register: tc is registered so that it lines up with the cycle in
  // which count shows 0 or the reloaded value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
    end
  end

  // Next-state logic. Priority is load > stop > start > decrement; rst is
  // handled in the register process above.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;

    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // A start with nothing to count is ignored.
          if (start && (count != ZERO)) state_nxt = RUN;
        end
        RUN: begin
          if (stop) begin
            state_nxt = IDLE;
          end else if (en) begin
            if (count > ONE) begin
              count_nxt = count - ONE;
            end else if (count == ONE) begin
              tc_nxt = 1'b1;
              if (auto_reload && (reload_reg != ZERO)) begin
                count_nxt = reload_reg;
              end else begin
                count_nxt = ZERO;
                state_nxt = DONE;
              end
            end
            // count==0 in RUN cannot occur; hold rather than wrap.
          end
        end
        DONE: begin
          if (start && (reload_reg != ZERO)) begin
            count_nxt = reload_reg;
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer
//   Directed testbench for down_counter_timer with hand-computed expectations.

module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  int total = 0;
  int bad   = 0;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] val,
                               input logic st, input logic sp, input logic e,
                               input logic ar);
    load        = ld;
    load_val    = val;
    start       = st;
    stop        = sp;
    en          = e;
    auto_reload = ar;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] exp_count,
                             input logic exp_busy, input logic exp_tc,
                             input logic exp_done);
    logic [WIDTH+2:0] obs;
    logic [WIDTH+2:0] exp;
    obs = {count, busy, tc, done};
    exp = {exp_count, exp_busy, exp_tc, exp_done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed count=%0d busy=%b tc=%b done=%b expected count=%0d busy=%b tc=%b done=%b",
             tag, count, busy, tc, done, exp_count, exp_busy, exp_tc, exp_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("reset", 0, 0, 0, 0);

    // 1: reset mid-run
    rst = 1'b0;
    applyStimulus(1, 5, 0, 0, 0, 0);
    tick();
    checkOutput("t1_load5", 5, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("t1_run", 5, 1, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("t1_rst_midrun", 0, 0, 0, 0);
    rst = 1'b0;

    // 2: one-shot from 3
    applyStimulus(1, 3, 0, 0, 0, 0);
    tick();
    checkOutput("t2_load3", 3, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    tick();
    checkOutput("t2_start", 3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("t2_cnt2", 2, 1, 0, 0);
    tick();
    checkOutput("t2_cnt1", 1, 1, 0, 0);
    tick();
    checkOutput("t2_terminal", 0, 0, 1, 1);
    tick();
    checkOutput("t2_done_hold", 0, 0, 0, 1);

    // 3: auto-reload period 2
    applyStimulus(1, 2, 0, 0, 0, 1);
    tick();
    checkOutput("t3_load2", 2, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 1);
    tick();
    checkOutput("t3_start", 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    tick();
    checkOutput("t3_cnt1a", 1, 1, 0, 0);
    tick();
    checkOutput("t3_reload_a", 2, 1, 1, 0);
    tick();
    checkOutput("t3_cnt1b", 1, 1, 0, 0);
    tick();
    checkOutput("t3_reload_b", 2, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1);
    tick();
    checkOutput("t3_stop", 2, 0, 0, 0);

    // 4: toggling enable from 4
    applyStimulus(1, 4, 0, 0, 0, 0);
    tick();
    checkOutput("t4_load4", 4, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("t4_start", 4, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); tick(); checkOutput("t4_e1", 3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0); tick(); checkOutput("t4_e2", 3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); tick(); checkOutput("t4_e3", 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0); tick(); checkOutput("t4_e4", 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); tick(); checkOutput("t4_e5", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0); tick(); checkOutput("t4_e6", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); tick(); checkOutput("t4_e7", 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0); tick(); checkOutput("t4_after", 0, 0, 0, 1);

    // 5: stop beats terminal decrement; load beats start
    applyStimulus(1, 1, 0, 0, 0, 0);
    tick();
    checkOutput("t5_load1", 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("t5_start", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    tick();
    checkOutput("t5_stop_wins", 1, 0, 0, 0);
    applyStimulus(1, 7, 1, 0, 0, 0);
    tick();
    checkOutput("t5_load_wins", 7, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t5_still_idle", 7, 0, 0, 0);

    // 6: start ignored at zero; restart from DONE; load mid-run
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t6_load0", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("t6_start_zero", 0, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0, 0);
    tick();
    checkOutput("t6_load5", 5, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("t6_start5", 5, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      checkOutput("t6_dec", i[WIDTH-1:0], 1, 0, 0);
    end
    tick();
    checkOutput("t6_terminal", 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("t6_restart", 5, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("t6_restart_dec", 4, 1, 0, 0);
    applyStimulus(1, 9, 0, 0, 0, 0);
    tick();
    checkOutput("t6_load_in_run", 9, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
